fetch_unit: RTL and testbench

- Instruction-fetch front end that drives the address side of the combinational instruction memory (`imem`) and consumes the returned word.
- Holds the PC and buffers fetched {pc, instr} pairs in a small in-order FIFO.
- Presents the pairs to decode through a valid/ready handshake.
- Supports control-flow redirect (flush + new PC) and halts fetching after an EBREAK.

---
 rtl/fetch_unit.sv | 100 ++++++++++
 tb/tb_fetch_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end.
//
// Drives the address of a combinational instruction memory from the PC register,
// buffers the returned {pc, instr} pairs in a small in-order FIFO, and hands them to
// decode over a valid/ready handshake. A redirect flushes the FIFO and restarts fetch
// at a new PC. Fetch stops after an EBREAK is buffered, until the next redirect or reset.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   imem_addr    byte address to imem (the PC register)
//   imem_instr   word returned by imem in the same cycle
//   out_valid    FIFO head holds a valid instruction (forced low during redirect)
//   out_ready    decode accepts the head this cycle
//   out_instr    head instruction, 0 when out_valid is low
//   out_pc       head address, 0 when out_valid is low
//   redirect     flush and restart fetch at redirect_pc
//   redirect_pc  new fetch address, bits [1:0] ignored
//   halted       fetch stopped after EBREAK
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        halted
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [31:0] Ebreak = 32'h0010_0073;

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e          state_q;
  logic [31:0]     pc_q;
  logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q;
  logic [31:0]     fifo_pc_q    [DEPTH];
  logic [31:0]     fifo_instr_q [DEPTH];

  logic push, pop;

  // A redirect cycle neither delivers nor fetches: stale entries must not leak out.
  always_comb begin
    out_valid = (count_q != '0) && !redirect;
    pop       = out_valid && out_ready;
    push      = (state_q == StRun) && !redirect && ((count_q < CW'(DEPTH)) || pop);
    out_instr = out_valid ? fifo_instr_q[rd_ptr_q] : 32'h0;
    out_pc    = out_valid ? fifo_pc_q[rd_ptr_q]    : 32'h0;
    imem_addr = pc_q;
    halted    = (state_q == StHalt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StRun;
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (redirect) begin
      state_q  <= StRun;
      pc_q     <= {redirect_pc[31:2], 2'b00};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        pc_q     <= pc_q + 32'd4;
        wr_ptr_q <= wr_ptr_q + AW'(1);
        // The EBREAK itself is still buffered; only later fetches stop.
        if (imem_instr == Ebreak) state_q <= StHalt;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: reads are masked by out_valid.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_pc_q[wr_ptr_q]    <= pc_q;
      fifo_instr_q[wr_ptr_q] <= imem_instr;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected {pc, instr} pairs, monitors
// pop and compare on every accepted handshake.
module tb_fetch_unit;

  localparam logic [31:0] Ebreak = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        out_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        ebrk_en = 1'b0;
  logic [31:0] imem_addr, imem_instr, out_instr, out_pc;
  logic        out_valid, halted;

  logic        w_ready = 1'b0;
  logic        w_redirect = 1'b0;
  logic [31:0] w_redirect_pc = 32'h0;
  logic [31:0] w_imem_addr, w_imem_instr, w_out_instr, w_out_pc;
  logic        w_out_valid, w_halted;

  int n_vec = 0;
  int n_bad = 0;
  logic [63:0] exp_q[$];
  logic [63:0] expw_q[$];

  always #5 clk = ~clk;

  assign imem_instr   = (ebrk_en && imem_addr == 32'd12) ? Ebreak : (32'hA000_0000 | imem_addr);
  assign w_imem_instr = 32'hA000_0000 | w_imem_addr;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .redirect(redirect), .redirect_pc(redirect_pc), .halted(halted)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_w (
    .clk(clk), .rst(rst), .imem_addr(w_imem_addr), .imem_instr(w_imem_instr),
    .out_valid(w_out_valid), .out_ready(w_ready), .out_instr(w_out_instr), .out_pc(w_out_pc),
    .redirect(w_redirect), .redirect_pc(w_redirect_pc), .halted(w_halted)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pair(input logic [31:0] pc);
    return {pc, 32'hA000_0000 | pc};
  endfunction

  task automatic do_reset();
    out_ready = 1'b0;
    redirect  = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  // Monitors: compare every accepted handshake with the next queued expectation.
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop_pc", out_pc, 32'hxxxx_xxxx);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("pop_pc", out_pc, e[63:32]);
        chk("pop_instr", out_instr, e[31:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && w_out_valid === 1'b1 && w_ready) begin
      if (expw_q.size() == 0) begin
        chk("unexpected_wrap_pop_pc", w_out_pc, 32'hxxxx_xxxx);
      end else begin
        logic [63:0] e;
        e = expw_q.pop_front();
        chk("wrap_pc", w_out_pc, e[63:32]);
        chk("wrap_instr", w_out_instr, e[31:0]);
      end
    end
  end

  initial begin
    // Streaming after reset, plus the wrapping instance alongside.
    do_reset();
    expw_q.delete();
    out_ready = 1'b1;
    w_ready   = 1'b1;
    for (int i = 0; i < 6; i++) exp_q.push_back(pair(32'(i * 4)));
    expw_q.push_back(pair(32'hFFFF_FFF8));
    expw_q.push_back(pair(32'hFFFF_FFFC));
    for (int i = 0; i < 4; i++) expw_q.push_back(pair(32'(i * 4)));
    @(negedge clk);
    chk("reset_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_pc", out_pc, 32'h0);
    chk("reset_instr", out_instr, 32'h0);
    chk("reset_halted", {31'b0, halted}, 32'd0);
    chk("reset_addr", imem_addr, 32'h0);
    chk("reset_addr_w", w_imem_addr, 32'hFFFF_FFF8);
    repeat (7) @(posedge clk);
    #1;
    out_ready = 1'b0;
    w_ready   = 1'b0;
    chk("stream_drained", 32'(exp_q.size()), 32'd0);
    chk("wrap_drained", 32'(expw_q.size()), 32'd0);

    // Backpressure: FIFO fills, PC holds, then drains back-to-back.
    do_reset();
    repeat (5) @(posedge clk);
    #1;
    @(negedge clk);
    chk("full_addr", imem_addr, 32'd8);
    chk("full_head_pc", out_pc, 32'd0);
    chk("full_valid", {31'b0, out_valid}, 32'd1);
    for (int i = 0; i < 4; i++) exp_q.push_back(pair(32'(i * 4)));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("drain_no_gap", {31'b0, out_valid}, 32'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_drained", 32'(exp_q.size()), 32'd0);

    // Redirect mid-stream to an unaligned target.
    do_reset();
    out_ready = 1'b1;
    exp_q.push_back(pair(32'd0));
    exp_q.push_back(pair(32'd4));
    exp_q.push_back(pair(32'd8));
    exp_q.push_back(pair(32'h100));
    exp_q.push_back(pair(32'h104));
    repeat (4) @(posedge clk);
    #1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    @(negedge clk);
    chk("redir_valid_c0", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    redirect = 1'b0;
    @(negedge clk);
    chk("redir_valid_c1", {31'b0, out_valid}, 32'd0);
    chk("redir_addr", imem_addr, 32'h100);
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("redir_drained", 32'(exp_q.size()), 32'd0);

    // EBREAK at 12 halts fetch; redirect resumes.
    ebrk_en = 1'b1;
    do_reset();
    out_ready = 1'b1;
    exp_q.push_back(pair(32'd0));
    exp_q.push_back(pair(32'd4));
    exp_q.push_back(pair(32'd8));
    exp_q.push_back({32'd12, Ebreak});
    exp_q.push_back(pair(32'h40));
    exp_q.push_back(pair(32'h44));
    repeat (8) @(posedge clk);
    #1;
    @(negedge clk);
    chk("halt_valid", {31'b0, out_valid}, 32'd0);
    chk("halt_flag", {31'b0, halted}, 32'd1);
    chk("halt_addr", imem_addr, 32'd16);
    @(posedge clk);
    #1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0040;
    @(negedge clk);
    chk("halt_redir_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    redirect = 1'b0;
    @(negedge clk);
    chk("unhalt_flag", {31'b0, halted}, 32'd0);
    chk("unhalt_addr", imem_addr, 32'h40);
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    ebrk_en   = 1'b0;
    chk("halt_drained", 32'(exp_q.size()), 32'd0);

    // Reset while full restarts at RESET_PC.
    do_reset();
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    chk("pre_rst_addr", imem_addr, 32'd8);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    exp_q.delete();
    exp_q.push_back(pair(32'd0));
    exp_q.push_back(pair(32'd4));
    exp_q.push_back(pair(32'd8));
    @(negedge clk);
    chk("midrst_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_addr", imem_addr, 32'd0);
    chk("midrst_halted", {31'b0, halted}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("midrst_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
